// File: rtl/bcd_timer.sv
// bcd_timer: multi-digit BCD up/down timer driven by an internal prescaler.
// The prescaler emits a one-cycle tick every CLK_DIV system clocks. Each tick
// steps the BCD count once, modulo LIMIT. The timer also supports pause,
// synchronous clear, and a validated parallel load, and it produces
// wrap and load-error strobes. All outputs are registered.
module bcd_timer #(
    parameter int CLK_DIV = 24000,
    parameter int DIGITS  = 2,
    parameter int LIMIT   = 60
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (CLK_DIV < 3) ? 1 : $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    // Converts an integer to its packed BCD form at elaboration time.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // The top of the count range, LIMIT-1, expressed in BCD.
    localparam logic [BW-1:0] BCD_MAX = to_bcd(LIMIT - 1);

    // Reject parameter combinations that cannot produce a meaningful timer.
    if (CLK_DIV < 2) begin : g_bad_div
        $error("bcd_timer: CLK_DIV must be >= 2 (got %0d)", CLK_DIV);
    end
    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
        $error("bcd_timer: DIGITS must be 1..6 (got %0d)", DIGITS);
    end
    if (LIMIT < 2 || LIMIT > 10**DIGITS) begin : g_bad_limit
        $error("bcd_timer: LIMIT must be 2..10^DIGITS (got %0d)", LIMIT);
    end

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [BW-1:0] r_bcd;
    logic          r_wrap;
    logic          r_load_err;

    logic [BW-1:0] w_inc;
    logic [BW-1:0] w_dec;
    logic [BW-1:0] w_step_val;
    logic          w_step_wrap;
    logic          w_load_ok;

    // BCD increment: ripple the carry through the digits, turning each 9 into 0.
    always_comb begin
        logic carry;
        w_inc = r_bcd;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // BCD decrement: ripple the borrow through the digits, turning each 0 into 9.
    always_comb begin
        logic borrow;
        w_dec  = r_bcd;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r_bcd[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Next count for a tick step, including the wrap at either end of the range.
    always_comb begin
        w_step_val  = w_inc;
        w_step_wrap = 1'b0;
        if (up) begin
            if (r_bcd == BCD_MAX) begin
                w_step_val  = '0;
                w_step_wrap = 1'b1;
            end else begin
                w_step_val  = w_inc;
            end
        end else begin
            if (r_bcd == '0) begin
                w_step_val  = BCD_MAX;
                w_step_wrap = 1'b1;
            end else begin
                w_step_val  = w_dec;
            end
        end
    end

    // Load validity: every digit must be decimal and the value must be in range.
    always_comb begin
        int  dec_val;
        int  weight;
        logic digits_ok;
        dec_val   = 0;
        weight    = 1;
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
            dec_val = dec_val + int'(load_val[4*i +: 4]) * weight;
            weight  = weight * 10;
        end
        w_load_ok = digits_ok && (dec_val < LIMIT);
    end

    // Prescaler and tick strobe. A pause freezes the phase so that the period resumes where it stopped.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (clr) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (en) begin
            if (r_presc == PRE_LAST) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Count register and strobes. Priority is clear, then a valid load, then the tick step.
    // A rejected load does not block the step.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_bcd      <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (clr) begin
            r_bcd      <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load && w_load_ok) begin
            r_bcd      <= load_val;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load;
            if (r_tick) begin
                r_bcd  <= w_step_val;
                r_wrap <= w_step_wrap;
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign bcd      = r_bcd;
    assign tick     = r_tick;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_timer.sv
// Testbench for bcd_timer. The bench checks the DUT against an integer-level model
// of the timer on every clock. It runs directed scenarios and then randomized traffic.
module tb_bcd_timer;

    localparam int CLK_DIV = 4;
    localparam int DIGITS  = 2;
    localparam int LIMIT   = 60;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] bcd;
    logic       tick;
    logic       wrap;
    logic       load_err;

    int errors = 0;
    int checks = 0;

    // Model state: prescaler phase and count as plain integers.
    int m_presc;
    int m_cnt;
    bit m_tick;
    bit m_wrap;
    bit m_err;

    always #5 clk = ~clk;

    bcd_timer #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS), .LIMIT(LIMIT)) dut (
        .clk(clk), .res(res), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap), .load_err(load_err)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_cnt   = 0;
        m_tick  = 0;
        m_wrap  = 0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        int hi;
        int lo;
        int n_presc;
        bit n_tick;
        bit valid;
        hi    = int'(load_val[7:4]);
        lo    = int'(load_val[3:0]);
        valid = (hi <= 9) && (lo <= 9) && ((hi * 10 + lo) < LIMIT);
        if (clr) begin
            model_reset();
        end else begin
            n_tick  = en && (m_presc == CLK_DIV - 1);
            n_presc = en ? (m_presc + 1) % CLK_DIV : m_presc;
            m_wrap  = 0;
            m_err   = load && !valid;
            if (load && valid) begin
                m_cnt = hi * 10 + lo;
            end else if (m_tick) begin
                if (up) begin
                    m_wrap = (m_cnt == LIMIT - 1);
                    m_cnt  = (m_cnt + 1) % LIMIT;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + LIMIT - 1) % LIMIT;
                end
            end
            m_tick  = n_tick;
            m_presc = n_presc;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("bcd", bcd, to_bcd(m_cnt));
        chk("tick", tick, m_tick);
        chk("wrap", wrap, m_wrap);
        chk("load_err", load_err, m_err);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 2 * CLK_DIV && !m_tick; i++) cyc();
        chk("tick_wait", tick, 1);
    endtask

    task automatic wait_step();
        int prev;
        bit seen;
        prev = m_cnt;
        seen = 0;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            cyc();
            if (m_cnt != prev) begin
                seen = 1;
                break;
            end
        end
        chk("step_wait", seen, 1);
    endtask

    initial begin
        int         wraps;
        int         ticks;
        logic [7:0] wrap_bcd;
        logic [7:0] held;

        // Reset state
        model_reset();
        #2;
        chk("rst_bcd", bcd, 8'h00);
        chk("rst_tick", tick, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", load_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        en  = 1'b1;
        up  = 1'b1;
        res = 1'b1;

        // First tick on cycle 4, first step on cycle 5, then a full lap
        repeat (3) cyc();
        chk("tick_c3", tick, 0);
        cyc();
        chk("tick_c4", tick, 1);
        cyc();
        chk("bcd_first", bcd, 8'h01);
        wraps    = 0;
        wrap_bcd = 8'hff;
        repeat (245) begin
            cyc();
            if (wrap) begin
                wraps++;
                wrap_bcd = bcd;
            end
        end
        chk("wrap_count", wraps, 1);
        chk("wrap_bcd", wrap_bcd, 8'h00);

        // Digit carry and borrow
        en = 1'b0; load = 1'b1; load_val = 8'h09;
        cyc();
        load = 1'b0;
        chk("load_09", bcd, 8'h09);
        en = 1'b1; up = 1'b1;
        wait_step();
        chk("carry_up", bcd, 8'h10);
        en = 1'b0; load = 1'b1; load_val = 8'h10;
        cyc();
        load = 1'b0; up = 1'b0; en = 1'b1;
        wait_step();
        chk("borrow_dn", bcd, 8'h09);
        en = 1'b0; load = 1'b1; load_val = 8'h00;
        cyc();
        load = 1'b0; en = 1'b1;
        wait_step();
        chk("down_wrap_bcd", bcd, 8'h59);
        chk("down_wrap", wrap, 1);

        // Pause with the prescaler at phase 2
        up = 1'b1;
        for (int i = 0; i < 2 * CLK_DIV && m_presc != 2; i++) cyc();
        en    = 1'b0;
        held  = to_bcd(m_cnt);
        ticks = 0;
        repeat (10) begin
            cyc();
            if (tick) ticks++;
        end
        chk("pause_ticks", ticks, 0);
        chk("pause_bcd", bcd, held);
        en = 1'b1;
        cyc();
        chk("resume_1", tick, 0);
        cyc();
        chk("resume_2", tick, 1);

        // Load validation
        en = 1'b0;
        cyc();
        cyc();
        held = to_bcd(m_cnt);
        load = 1'b1; load_val = 8'h60;
        cyc();
        chk("ld60_err", load_err, 1);
        chk("ld60_bcd", bcd, held);
        load_val = 8'h3A;
        cyc();
        chk("ld3a_err", load_err, 1);
        chk("ld3a_bcd", bcd, held);
        load_val = 8'h45;
        cyc();
        chk("ld45_bcd", bcd, 8'h45);
        chk("ld45_err", load_err, 0);
        load = 1'b0;
        cyc();
        chk("ld_idle_err", load_err, 0);

        // Priority: clr+load on a tick cycle, then load on a tick cycle
        en = 1'b1;
        wait_tick();
        clr = 1'b1; load = 1'b1; load_val = 8'h33;
        cyc();
        clr = 1'b0; load = 1'b0;
        chk("clr_bcd", bcd, 8'h00);
        chk("clr_tick", tick, 0);
        repeat (3) cyc();
        chk("clr_tick_c3", tick, 0);
        cyc();
        chk("clr_tick_c4", tick, 1);
        load = 1'b1; load_val = 8'h20;
        cyc();
        load = 1'b0;
        chk("ldtick_bcd", bcd, 8'h20);
        chk("ldtick_wrap", wrap, 0);
        cyc();
        chk("ldtick_nostep", bcd, 8'h20);

        // Asynchronous reset mid-count
        en = 1'b0; load = 1'b1; load_val = 8'h37;
        cyc();
        load = 1'b0;
        chk("pre_rst_bcd", bcd, 8'h37);
        #2 res = 1'b0;
        #1;
        chk("arst_bcd", bcd, 8'h00);
        chk("arst_tick", tick, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_err", load_err, 0);
        model_reset();
        #2 res = 1'b1;
        en = 1'b1; up = 1'b1;
        repeat (3) cyc();
        chk("arst_tick_c3", tick, 0);
        cyc();
        chk("arst_tick_c4", tick, 1);
        cyc();
        chk("arst_bcd_1", bcd, 8'h01);

        // Randomized traffic against the model
        repeat (3000) begin
            en   = ($urandom_range(0, 9) != 0);
            up   = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0)
                load_val = 8'($urandom_range(0, 255));
            else
                load_val = to_bcd(int'($urandom_range(0, LIMIT - 1)));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
- Parametrised multi-digit BCD timer. Successor to the single-digit 0–9 seconds counter.
- An internal prescaler turns the system clock into a one-cycle tick every CLK_DIV cycles.
- On each tick, an N-digit BCD count steps up or down modulo LIMIT.
- Adds enable/pause, synchronous clear, parallel load with validity check, direction control, and wrap/error strobes. Feeds display and clock/alarm logic.

Parameters:
- CLK_DIV, 24000, system clock cycles per tick (>= 2); prescaler width = $clog2(CLK_DIV).
- DIGITS, 2, number of BCD digits (1..6).
- LIMIT, 60, count modulus; count range 0..LIMIT-1 (2 <= LIMIT <= 10^DIGITS).

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- en  in  1  1 = prescaler runs; 0 = pause (prescaler and count hold).
- up  in  1  1 = count up, 0 = count down; sampled on tick cycles.
- clr  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous parallel load request.
- load_val  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- bcd  out  4*DIGITS  current BCD count (registered).
- tick  out  1  one-cycle strobe, prescaler period elapsed.
- wrap  out  1  one-cycle strobe, count wrapped this step.
- load_err  out  1  one-cycle strobe, load rejected.

Behaviour:
- Reset (res=0, asynchronous):
  - prescaler=0, bcd=0, tick=0, wrap=0, load_err=0.
  - Release is synchronous to clk.
- Prescaler:
  - With en=1, counts 0..CLK_DIV-1.
  - At CLK_DIV-1: prescaler<=0 and tick<=1. Otherwise tick<=0.
  - With en=0: prescaler holds, tick<=0.
  - Tick period is exactly CLK_DIV cycles while en=1.
- Count step:
  - On a cycle with tick=1 (registered), bcd updates at the next edge. Latency: prescaler terminal -> tick 1 cycle -> bcd 1 more cycle.
  - Up: bcd+1 with per-digit BCD carry (digit 9 -> 0, carry into next digit). From LIMIT-1 -> 0, with wrap<=1 in the same edge bcd changes.
  - Down: per-digit borrow (digit 0 -> 9). From 0 -> LIMIT-1, with wrap<=1.
  - wrap is 0 on every other cycle.
  - A step on the same cycle en falls still completes, because tick was already registered.
- Priority each cycle: clr > load > tick step.
  - clr=1: bcd<=0, prescaler<=0, tick<=0. A pending tick step is discarded. No wrap.
  - load=1 with a valid value: bcd<=load_val. Prescaler is not reset. A coincident tick step is discarded.
  - A load is valid only if every digit <= 9 and the decimal value < LIMIT.
  - Invalid load: bcd unchanged, load_err<=1 for one cycle, and a coincident tick step still occurs.
  - load held high re-loads every cycle; count is frozen meanwhile.
- Direction change takes effect on the next tick; no glitch, no extra step.
- All outputs are registered; no combinational input-to-output paths.
- LIMIT outside range, or CLK_DIV < 2, is an elaboration error ($error in generate).

Test Plan (bench uses CLK_DIV=4, DIGITS=2, LIMIT=60, 10 ns clock):
- Reset then en=1, up=1:
  - tick high on cycles 4, 8, 12, ... after release.
  - bcd shows 0x01, 0x02, ... one cycle after each tick.
  - After 60 ticks, bcd returns to 0x00 with a single wrap pulse coinciding with the 0x59 -> 0x00 change.
- Digit carry:
  - load 0x09, up: next step gives 0x10.
  - load 0x10, up=0: next step gives 0x09.
  - From 0x00 counting down gives 0x59 with wrap=1.
- Pause:
  - Drop en for 10 cycles mid-period with prescaler=2.
  - bcd and prescaler hold; no tick.
  - After en returns, next tick arrives exactly 2 cycles later.
- Load validation:
  - load 0x60 -> load_err=1, bcd unchanged.
  - load 0x3A -> load_err=1.
  - load 0x45 -> bcd=0x45, load_err=0.
- Priority collisions:
  - clr and load together on a tick cycle -> bcd=0x00, prescaler=0, next tick 4 cycles later.
  - load 0x20 on a tick cycle -> bcd=0x20, no step.
- Async reset mid-count:
  - res low for 3 ns between edges at bcd=0x37 -> all outputs 0 immediately.
  - Counting resumes from 0x00 with a full 4-cycle prescaler period after release.
